// File: rtl/perf_mon_pkg.sv
// Shared widths, record types and the saturating adder used by the
// transaction latency / bandwidth monitor.
package perf_mon_pkg;

    localparam int DEF_ID_W    = 4;
    localparam int DEF_TS_W    = 32;
    localparam int DEF_BYTES_W = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_WIN_W   = 16;

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        logic [DEF_TS_W-1:0] cycles;
    } lat_rec_t;

    typedef struct packed {
        logic [DEF_ACC_W-1:0] bytes;
        logic [DEF_ACC_W-1:0] txns;
    } bw_rec_t;

    // Width-generic: the result clamps at 2**w-1 (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [64:0] s;
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/perf_txn_latency_monitor_if.sv
// Monitored request/response channel pair. The monitor only observes,
// so it uses the all-input mon modport.
interface perf_txn_latency_monitor_if
    import perf_mon_pkg::*;
#(
    parameter int ID_W    = DEF_ID_W,
    parameter int BYTES_W = DEF_BYTES_W
) ();
    logic               req_valid;
    logic               req_ready;
    logic [ID_W-1:0]    req_id;
    logic [BYTES_W-1:0] req_bytes;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_last;

    modport master (output req_valid, req_id, req_bytes, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_last);
    modport slave  (input  req_valid, req_id, req_bytes, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_last);
    modport mon    (input  req_valid, req_ready, req_id, req_bytes,
                    input  rsp_valid, rsp_ready, rsp_id, rsp_last);
endinterface

// File: rtl/perf_bw_window.sv
// Window counter plus byte/transaction accumulators; emits one bandwidth
// record per closed window.
module perf_bw_window
    import perf_mon_pkg::*;
#(
    parameter int BYTES_W = DEF_BYTES_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [WIN_W-1:0]   i_win_len,
    input  logic               i_req_fire,
    input  logic [BYTES_W-1:0] i_req_bytes,
    input  logic               i_cmp_fire,
    output logic               o_bw_valid,
    output logic [ACC_W-1:0]   o_bw_bytes,
    output logic [ACC_W-1:0]   o_bw_txns
);
    logic [WIN_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_bytes, r_txns, r_bw_bytes, r_bw_txns;
    logic             r_bw_valid;
    logic             w_last;
    logic [ACC_W-1:0] w_bytes_nxt, w_txns_nxt;

    // ">=" so a shrunken win_len closes the current window right away.
    assign w_last      = (r_cnt >= (i_win_len - WIN_W'(1)));
    assign w_bytes_nxt = ACC_W'(sat_add(64'(r_bytes),
                                        i_req_fire ? 64'(i_req_bytes) : 64'd0, ACC_W));
    assign w_txns_nxt  = ACC_W'(sat_add(64'(r_txns), 64'(i_cmp_fire), ACC_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_txns     <= '0;
            r_bw_valid <= 1'b0;
            r_bw_bytes <= '0;
            r_bw_txns  <= '0;
        end else if (i_win_len == '0) begin
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_txns     <= '0;
            r_bw_valid <= 1'b0;
        end else if (i_en) begin
            if (w_last) begin
                r_bw_valid <= 1'b1;
                r_bw_bytes <= w_bytes_nxt;
                r_bw_txns  <= w_txns_nxt;
                r_cnt      <= '0;
                r_bytes    <= '0;
                r_txns     <= '0;
            end else begin
                r_bw_valid <= 1'b0;
                r_cnt      <= r_cnt + WIN_W'(1);
                r_bytes    <= w_bytes_nxt;
                r_txns     <= w_txns_nxt;
            end
        end else begin
            r_bw_valid <= 1'b0;
        end
    end

    assign o_bw_valid = r_bw_valid;
    assign o_bw_bytes = r_bw_bytes;
    assign o_bw_txns  = r_bw_txns;
endmodule

// File: rtl/perf_txn_latency_monitor.sv
// Passive latency/bandwidth monitor: per-ID timestamp table, latency records
// on completion, and a windowed bandwidth record from perf_bw_window.
module perf_txn_latency_monitor
    import perf_mon_pkg::*;
#(
    parameter int ID_W    = DEF_ID_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int BYTES_W = DEF_BYTES_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WIN_W-1:0]           win_len,
    perf_txn_latency_monitor_if.mon    bus,
    output logic                       lat_valid,
    output logic [ID_W-1:0]            lat_id,
    output logic [TS_W-1:0]            lat_cycles,
    output logic [TS_W-1:0]            lat_max,
    output logic                       bw_valid,
    output logic [ACC_W-1:0]           bw_bytes,
    output logic [ACC_W-1:0]           bw_txns,
    output logic [ID_W:0]              outstanding,
    output logic                       err_dup_id,
    output logic                       err_orphan_rsp
);
    localparam int SLOTS = 1 << ID_W;

    logic [TS_W-1:0]  r_ts;
    logic [SLOTS-1:0] r_busy;
    logic [TS_W-1:0]  r_start [SLOTS];
    logic [ID_W:0]    r_out;
    logic             r_lat_valid, r_err_dup, r_err_orph;
    logic [ID_W-1:0]  r_lat_id;
    logic [TS_W-1:0]  r_lat_cycles, r_lat_max;

    logic             w_req_fire, w_cmp, w_cmp_fire, w_same, w_dup, w_inc;
    logic [TS_W-1:0]  w_lat;

    assign w_req_fire = bus.req_valid & bus.req_ready & en;
    assign w_cmp      = bus.rsp_valid & bus.rsp_ready & bus.rsp_last;
    assign w_cmp_fire = w_cmp & r_busy[bus.rsp_id];
    // A same-ID completion retires the entry before the request reuses it.
    assign w_same     = w_cmp_fire & (bus.rsp_id == bus.req_id);
    assign w_dup      = w_req_fire & r_busy[bus.req_id] & ~w_same;
    assign w_inc      = w_req_fire & ~w_dup;
    // Modular subtraction keeps latency correct across timestamp wrap.
    assign w_lat      = r_ts - r_start[bus.rsp_id];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts         <= '0;
            r_busy       <= '0;
            r_out        <= '0;
            r_lat_valid  <= 1'b0;
            r_lat_id     <= '0;
            r_lat_cycles <= '0;
            r_lat_max    <= '0;
            r_err_dup    <= 1'b0;
            r_err_orph   <= 1'b0;
        end else begin
            r_ts        <= r_ts + TS_W'(1);
            r_lat_valid <= w_cmp_fire;
            r_out       <= r_out + (ID_W+1)'(w_inc) - (ID_W+1)'(w_cmp_fire);
            if (w_cmp_fire) begin
                r_busy[bus.rsp_id] <= 1'b0;
                r_lat_id           <= bus.rsp_id;
                r_lat_cycles       <= w_lat;
                if (w_lat > r_lat_max) r_lat_max <= w_lat;
            end
            if (w_req_fire) r_busy[bus.req_id] <= 1'b1;
            if (w_dup) r_err_dup <= 1'b1;
            if (w_cmp & ~r_busy[bus.rsp_id]) r_err_orph <= 1'b1;
        end
    end

    // Start stamps need no reset: they are only read while the slot is busy.
    always_ff @(posedge clk) begin
        if (w_req_fire) r_start[bus.req_id] <= r_ts;
    end

    perf_bw_window #(
        .BYTES_W (BYTES_W),
        .ACC_W   (ACC_W),
        .WIN_W   (WIN_W)
    ) u_bw (
        .clk         (clk),
        .reset       (reset),
        .i_en        (en),
        .i_win_len   (win_len),
        .i_req_fire  (w_req_fire),
        .i_req_bytes (bus.req_bytes),
        .i_cmp_fire  (w_cmp_fire),
        .o_bw_valid  (bw_valid),
        .o_bw_bytes  (bw_bytes),
        .o_bw_txns   (bw_txns)
    );

    assign lat_valid      = r_lat_valid;
    assign lat_id         = r_lat_id;
    assign lat_cycles     = r_lat_cycles;
    assign lat_max        = r_lat_max;
    assign outstanding    = r_out;
    assign err_dup_id     = r_err_dup;
    assign err_orphan_rsp = r_err_orph;
endmodule

// File: tb/tb_perf_txn_latency_monitor.sv
// Directed bench for perf_txn_latency_monitor; a second 8-bit-timestamp
// instance on the same channel exercises latency across timestamp wrap.
module tb_perf_txn_latency_monitor;
    import perf_mon_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] win_len = '0;

    perf_txn_latency_monitor_if bus ();

    logic        lat_valid, bw_valid, err_dup_id, err_orphan_rsp;
    logic [3:0]  lat_id;
    logic [31:0] lat_cycles, lat_max, bw_bytes, bw_txns;
    logic [4:0]  outstanding;

    logic        d8_lat_valid, d8_bw_valid, d8_err_dup, d8_err_orph;
    logic [3:0]  d8_lat_id;
    logic [7:0]  d8_lat_cycles, d8_lat_max;
    logic [31:0] d8_bw_bytes, d8_bw_txns;
    logic [4:0]  d8_out;

    perf_txn_latency_monitor u_dut (
        .clk(clk), .reset(reset), .en(en), .win_len(win_len), .bus(bus),
        .lat_valid(lat_valid), .lat_id(lat_id), .lat_cycles(lat_cycles),
        .lat_max(lat_max), .bw_valid(bw_valid), .bw_bytes(bw_bytes),
        .bw_txns(bw_txns), .outstanding(outstanding),
        .err_dup_id(err_dup_id), .err_orphan_rsp(err_orphan_rsp)
    );

    perf_txn_latency_monitor #(.TS_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .win_len(win_len), .bus(bus),
        .lat_valid(d8_lat_valid), .lat_id(d8_lat_id), .lat_cycles(d8_lat_cycles),
        .lat_max(d8_lat_max), .bw_valid(d8_bw_valid), .bw_bytes(d8_bw_bytes),
        .bw_txns(d8_bw_txns), .outstanding(d8_out),
        .err_dup_id(d8_err_dup), .err_orphan_rsp(d8_err_orph)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ts_m = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ts_m++;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_ready = 1'b1;
        bus.req_id    = '0;
        bus.req_bytes = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.rsp_id    = '0;
        bus.rsp_last  = 1'b0;
    endtask

    task automatic req(input logic [3:0] id, input logic [7:0] b);
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        bus.req_bytes = b;
    endtask

    task automatic rsp(input logic [3:0] id, input logic last);
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id;
        bus.rsp_last  = last;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".lat_valid"},  lat_valid, 0);
        chk({tag, ".lat_id"},     lat_id, 0);
        chk({tag, ".lat_cycles"}, lat_cycles, 0);
        chk({tag, ".lat_max"},    lat_max, 0);
        chk({tag, ".bw_valid"},   bw_valid, 0);
        chk({tag, ".bw_bytes"},   bw_bytes, 0);
        chk({tag, ".bw_txns"},    bw_txns, 0);
        chk({tag, ".outstanding"}, outstanding, 0);
        chk({tag, ".err_dup"},    err_dup_id, 0);
        chk({tag, ".err_orph"},   err_orphan_rsp, 0);
    endtask

    logic early;

    initial begin
        idle();
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");

        @(negedge clk);
        reset = 1'b0;
        ts_m  = 0;

        // Basic latency: request id 3 at ts 10, completion at ts 27.
        while (ts_m < 10) tick();
        req(4'd3, 8'd8);
        tick(); idle();
        chk("a.out1", outstanding, 1);
        while (ts_m < 27) tick();
        rsp(4'd3, 1'b1);
        tick(); idle();
        chk("a.lat_valid",  lat_valid, 1);
        chk("a.lat_id",     lat_id, 3);
        chk("a.lat_cycles", lat_cycles, 17);
        chk("a.lat_max",    lat_max, 17);
        chk("a.out0",       outstanding, 0);
        tick();
        chk("a.strobe", lat_valid, 0);

        // Wrap: the 8-bit instance sees request at 251, completion at 4.
        while (ts_m < 251) tick();
        req(4'd7, 8'd0);
        tick(); idle();
        while (ts_m < 260) tick();
        rsp(4'd7, 1'b1);
        tick(); idle();
        chk("w.valid8",  d8_lat_valid, 1);
        chk("w.cycles8", d8_lat_cycles, 9);
        chk("w.max8",    d8_lat_max, 17);

        // Window of 8: 64+32+16 bytes, two completions.
        tick();
        win_len = 16'd8;
        early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: req(4'd1, 8'd64);
                2: req(4'd4, 8'd32);
                3: rsp(4'd1, 1'b1);
                5: req(4'd6, 8'd16);
                6: rsp(4'd4, 1'b1);
                default: ;
            endcase
            tick(); idle();
            if (k < 7) early |= bw_valid;
        end
        chk("bw.early", early, 0);
        chk("bw.valid", bw_valid, 1);
        chk("bw.bytes", bw_bytes, 112);
        chk("bw.txns",  bw_txns, 2);
        early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 7) early |= bw_valid;
        end
        chk("bw2.early", early, 0);
        chk("bw2.valid", bw_valid, 1);
        chk("bw2.bytes", bw_bytes, 0);
        chk("bw2.txns",  bw_txns, 0);
        win_len = '0;
        tick();
        chk("bw.off", bw_valid, 0);
        chk("bw.out", outstanding, 1);

        // Same-cycle completion and new request on id 2.
        req(4'd2, 8'd4);
        tick(); idle();
        chk("s.out2", outstanding, 2);
        req(4'd2, 8'd4);
        rsp(4'd2, 1'b1);
        tick(); idle();
        chk("s.lat_valid",  lat_valid, 1);
        chk("s.lat_id",     lat_id, 2);
        chk("s.lat_cycles", lat_cycles, 1);
        chk("s.out",        outstanding, 2);
        chk("s.err_dup",    err_dup_id, 0);
        chk("s.lat_max",    lat_max, 17);

        // Non-last beat on busy id 2 is ignored.
        rsp(4'd2, 1'b0);
        tick(); idle();
        chk("nl.lat_valid", lat_valid, 0);
        chk("nl.out",       outstanding, 2);

        // Duplicate request on id 5.
        req(4'd5, 8'd1);
        tick(); idle();
        chk("d.out3", outstanding, 3);
        chk("d.err0", err_dup_id, 0);
        req(4'd5, 8'd1);
        tick(); idle();
        chk("d.err1", err_dup_id, 1);
        chk("d.out",  outstanding, 3);

        // Orphan completion on idle id 9.
        rsp(4'd9, 1'b1);
        tick(); idle();
        chk("o.err",       err_orphan_rsp, 1);
        chk("o.lat_valid", lat_valid, 0);
        chk("o.out",       outstanding, 3);

        // Reset with 4 outstanding (ids 6, 2, 5, 11).
        req(4'd11, 8'd1);
        tick(); idle();
        chk("r.out4", outstanding, 4);
        reset = 1'b1;
        #2;
        chk_all_zero("rr");
        @(negedge clk);
        reset = 1'b0;
        ts_m  = 0;
        tick();
        chk("r.err_clear", err_orphan_rsp, 0);
        rsp(4'd6, 1'b1);
        tick(); idle();
        chk("r.orph",      err_orphan_rsp, 1);
        chk("r.lat_valid", lat_valid, 0);
        chk("r.out",       outstanding, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/perf_txn_latency_monitor.md
Name: perf_txn_latency_monitor

Overview:
- Passive RTL monitor on a request/response channel pair (e.g. native-interface read or write) in full-system performance simulations.
- Timestamps each request handshake per transaction ID, measures request-to-response latency, and accumulates per-window byte and transaction counts.
- Emits one latency record per completed transaction and one bandwidth record per window.
- These records are the producer side of the newperf latency/bandwidth scoreboard tooling.
- Never drives the monitored channel.

Parameters:
- ID_W, 4, transaction ID width; the tracking table has 2**ID_W slots indexed by ID.
- TS_W, 32, width of the free-running timestamp and of latency values.
- BYTES_W, 8, width of the per-request byte count.
- ACC_W, 32, width of the window byte and transaction accumulators.
- WIN_W, 16, width of the window-length control.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  monitoring enable; when low, no new allocations, no accumulation, window counter held.
- win_len  in  WIN_W  window length in cycles; 0 disables bandwidth records.
- req_valid  in  1  monitored request valid.
- req_ready  in  1  monitored request ready.
- req_id  in  ID_W  request ID.
- req_bytes  in  BYTES_W  bytes moved by the request.
- rsp_valid  in  1  monitored response valid.
- rsp_ready  in  1  monitored response ready.
- rsp_id  in  ID_W  response ID.
- rsp_last  in  1  final beat of the response.
- lat_valid  out  1  latency record strobe, one cycle.
- lat_id  out  ID_W  ID of the completed transaction.
- lat_cycles  out  TS_W  measured latency.
- lat_max  out  TS_W  running maximum latency since reset.
- bw_valid  out  1  window record strobe, one cycle.
- bw_bytes  out  ACC_W  bytes in the closed window.
- bw_txns  out  ACC_W  completed transactions in the closed window.
- outstanding  out  ID_W+1  number of busy slots.
- err_dup_id  out  1  sticky: request allocated an already-busy ID.
- err_orphan_rsp  out  1  sticky: last response beat arrived for an idle ID.

Behaviour:
- Reset: every output is 0, all slots are idle, timestamp is 0, window counter is 0.
- Timestamp: free-running, increments every cycle (independent of en), wraps modulo 2**TS_W.
- Request handshake: req_valid & req_ready & en. The slot for req_id becomes busy and stores the current timestamp.
- Duplicate request: if the slot is already busy, set err_dup_id, overwrite the timestamp, and leave outstanding unchanged.
- Completion: rsp_valid & rsp_ready & rsp_last.
  - Busy slot: the slot becomes idle; next cycle lat_valid=1, lat_id=rsp_id, lat_cycles=(ts_now - ts_start) mod 2**TS_W, so latency stays correct across timestamp wrap. Minimum legal latency is 1.
  - Idle slot: set err_orphan_rsp; no latency record.
  - Non-last response beats are ignored.
- Completions are counted even when en is low, so drained transactions still report latency.
- lat_max updates in the same cycle lat_valid is asserted, to max(lat_max, lat_cycles).
- Same-cycle request and completion:
  - Same ID: completion retires the old entry first, then the request allocates fresh. No duplicate error; outstanding is unchanged.
  - Different IDs: both take effect; outstanding is unchanged.
- outstanding updates the cycle after the handshakes and is never above 2**ID_W.
- Window (win_len != 0, en high):
  - The counter runs 0..win_len-1.
  - Request handshakes add req_bytes to the byte accumulator; completions add 1 to the transaction accumulator.
  - In the cycle the counter equals win_len-1, the accumulators including that cycle's events are registered into bw_bytes/bw_txns with bw_valid=1 on the next cycle. The accumulators then restart from 0 and the counter wraps.
  - Accumulators saturate at all-ones.
  - Changing win_len mid-window takes effect when the counter next reaches the new win_len-1. If the counter is already at or above the new value, the window closes immediately on the next cycle.
  - win_len=0: counter and accumulators are held at 0, no bw_valid.
- Error flags clear only on reset.
- Reset mid-operation: all in-flight slots are discarded; no records are emitted for them.

Decomposition:
- Shared package perf_mon_pkg:
  - lat_rec_t typedef (id, cycles).
  - bw_rec_t typedef (bytes, txns).
  - Default widths.
  - Saturating-add function.
- One sub-module perf_bw_window: window counter, both accumulators, and the bw record register.
- The slot table and latency path stay in the top module.

Test Plan:
- Request id 3 at timestamp 10, last response id 3 at timestamp 27 -> lat_valid one cycle later, lat_id=3, lat_cycles=17, lat_max=17, outstanding 1 then 0.
- Request at timestamp 2**32-5, completion at timestamp 4 -> lat_cycles=9.
- win_len=8; three requests of 64, 32 and 16 bytes in cycles 0-7; two completions -> single bw_valid with bw_bytes=112, bw_txns=2; the next window starts at 0.
- Second request on busy id 5 -> err_dup_id=1, outstanding unchanged. Last response on idle id 9 -> err_orphan_rsp=1, no lat_valid.
- Same-cycle completion and new request on id 2 -> one latency record, id 2 busy, no error, outstanding unchanged.
- Assert reset with 4 outstanding IDs -> all outputs 0; later responses on those IDs flag err_orphan_rsp.
